des_sbox_pipe: RTL and testbench
================================

Name: des_sbox_pipe

Overview:
- Pipelined DES substitution stage: takes the 48-bit expanded-and-key-mixed word and applies all eight FIPS 46-3 S-boxes in parallel, producing 32 bits.
- P permutation is optional.
- Successor to the single-table combinational S-box LUTs.
- Sits between the E-expansion/key-XOR and the Feistel XOR in the DES round datapath.
- Valid/ready on both sides with full backpressure, at one result per cycle.

Parameters:
- PIPE_STAGES, 2, number of register stages (1 or 2). 1 = S-box output registered only. 2 = input register plus output register.
- APPLY_P, 1, 1 = apply the DES P permutation to the 32-bit S-box result before the output register. 0 = raw concatenated S-box outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  stage can accept input this cycle
- in_data  in  48  S-box input, bits [47:42] feed S1 … bits [5:0] feed S8
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output this cycle
- out_data  out  32  result; S1 nibble at [31:28] … S8 at [3:0] (before P)
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Per S-box i, 6-bit chunk b[5:0]:
  - row = {b[5], b[0]}, column = b[4:1].
  - Value is taken from the standard DES S-box i table. All 8 tables are fixed constants, 4-bit entries.
- Transfer rule: a transfer occurs on a rising clk when valid && ready on that interface.
- Each stage holds a valid flag and a data register. A stage loads when it is empty or its contents are leaving this cycle.
- in_ready = !v_first || advance_first, where advance_first is that stage's downstream transfer condition. Combinational from out_ready; no skid buffer.
- PIPE_STAGES=1:
  - The registered S-box(+P) result is out_data.
  - Latency is 1 cycle from input transfer to out_valid.
- PIPE_STAGES=2:
  - Stage A registers in_data.
  - Stage B registers S-box(+P) of stage A.
  - Latency is 2 cycles. Stage A advances when !v_B || out_ready.
- Throughput: with out_ready held high, one word per cycle sustained; no bubbles inserted.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - Upstream stages fill, then in_ready deasserts.
  - No data is lost or duplicated.
- Simultaneous load and unload on a full stage: new data replaces old in the same cycle; the valid flag stays 1.
- in_data is ignored when in_valid=0. Data registers may load don't-care, but valid flags must stay 0.
- Reset values:
  - All valid flags = 0, so out_valid = 0 and busy = 0.
  - out_data = 0.
  - in_ready = 1 (first cycle after rst deasserts).
- Reset mid-operation: all in-flight words are discarded. No out_valid in the cycle after rst is sampled high.
- busy = OR of all stage valid flags.
- Illegal PIPE_STAGES (not 1 or 2): elaboration error via generate-time check.

Test Plan:
- Zero vector, APPLY_P=0, PIPE_STAGES=2: in_data=48'h000000000000, out_ready=1 -> out_data=32'hEFA72C4D exactly 2 cycles after the input transfer.
- All-ones vector, APPLY_P=0: in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB. With APPLY_P=1, out_data must equal P(32'hD9CE3DCB) as computed by the bench model.
- Streaming, both PIPE_STAGES values: 1000 random words, in_valid=1 and out_ready=1 continuously -> one output per cycle, order preserved, every word matches the reference model. Latency is 1 or 2 accordingly.
- Backpressure:
  - Drive 4 words while out_ready=0.
  - Expect in_ready to drop after PIPE_STAGES words are accepted, and out_data to hold stable.
  - Release out_ready: the words drain in order with no loss or duplication.
- Random valid/ready toggling (50% each), 5000 words -> scoreboard exact match, no drops.
- Reset mid-stream: assert rst for 1 cycle with 2 words in flight -> out_valid=0 and busy=0 next cycle; in_ready=1; the next accepted word is output correctly.

Source files
------------

// File: rtl/des_sbox_pipe.sv
// -----------------------------------------------------------------------------
// des_sbox_pipe
//
// Pipelined DES substitution stage. Takes the 48-bit word coming out of the
// E-expansion / round-key XOR and runs all eight DES S-boxes in parallel,
// giving a 32-bit result. The DES P permutation can be folded in ahead of the
// output register. Valid/ready handshake on both sides with full backpressure
// and one result per cycle when the sink keeps up.
//
// Parameters
//   PIPE_STAGES  1: S-box result registered only (latency 1)
//                2: input register plus result register (latency 2)
//   APPLY_P      1: P permutation applied, 0: raw S1..S8 nibbles
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   in_valid   input word valid
//   in_ready   stage can accept an input word this cycle
//   in_data    48-bit S-box input, [47:42] -> S1 ... [5:0] -> S8
//   out_valid  output word valid
//   out_ready  downstream accepts the output word this cycle
//   out_data   32-bit result, S1 nibble at [31:28] ... S8 at [3:0] (before P)
//   busy       some pipeline stage holds a valid word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module des_sbox_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter int APPLY_P     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  // Each S-box packed as 64 nibbles, row-major (index = row*16 + col),
  // entry 0 in the most significant nibble. Element 0 is S1.
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P permutation: output bit k (1 = MSB) takes input bit P_TAB[k-1] (1 = MSB).
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [31:0] sbox_all(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[6'(42 - 6*i) +: 6];
      // Row comes from the outer bits, column from the inner four.
      idx = {b[5], b[0], b[4:1]};
      y[5'(28 - 4*i) +: 4] = SBOX_TAB[3'(i)][8'(252 - 4*int'(idx)) +: 4];
    end
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int k = 0; k < 32; k++) begin
      y[5'(31 - k)] = x[5'(32 - P_TAB[5'(k)])];
    end
    return y;
  endfunction

  // Output stage (present in both configurations).
  logic        b_valid_q, b_valid_d;
  logic [31:0] b_data_q,  b_data_d;
  logic        b_advance;   // output register may load this cycle
  logic        src_valid;   // word presented to the output stage
  logic [47:0] src_data;
  logic [31:0] sbox_raw;
  logic [31:0] sbox_res;

  assign b_advance = !b_valid_q || out_ready;
  assign sbox_raw  = sbox_all(src_data);
  assign sbox_res  = (APPLY_P != 0) ? perm_p(sbox_raw) : sbox_raw;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (b_advance) begin
      b_valid_d = src_valid;
      // Data only moves with a real word, so an idle cycle never disturbs it.
      if (src_valid) b_data_d = sbox_res;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic        a_valid_q, a_valid_d;
      logic [47:0] a_data_q,  a_data_d;

      always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        if (in_ready) begin
          a_valid_d = in_valid;
          if (in_valid) a_data_d = in_data;
        end
      end

      // NOTE: the input data register carries no reset; its valid flag is
      // reset and qualifies it, so its contents are never observed when stale.
      always_ff @(posedge clk) begin
        if (rst) a_valid_q <= 1'b0;
        else     a_valid_q <= a_valid_d;
        a_data_q <= a_data_d;
      end

      // Stage A empties whenever the output register can take its word.
      assign in_ready  = !a_valid_q || b_advance;
      assign src_valid = a_valid_q;
      assign src_data  = a_data_q;
      assign busy      = a_valid_q || b_valid_q;
    end else if (PIPE_STAGES == 1) begin : g_one
      assign in_ready  = b_advance;
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign busy      = b_valid_q;
    end else begin : g_bad
      $error("des_sbox_pipe: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_des_sbox_pipe.sv
// -----------------------------------------------------------------------------
// tb_des_sbox_pipe
//
// Three instances of des_sbox_pipe (two-stage raw, two-stage with P,
// one-stage raw) share one stimulus stream. Each instance has its own
// scoreboard fed by a reference model built from the DES tables in plain
// arithmetic; the scoreboard also predicts out_valid from word age, in_ready
// from occupancy and busy from emptiness every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_des_sbox_pipe;

  localparam int NDUT = 3;
  localparam int CFG_PS [NDUT] = '{2, 2, 1};
  localparam int CFG_AP [NDUT] = '{0, 1, 0};

  // S_TAB[box][row][col], standard DES S-boxes S1..S8.
  localparam int S_TAB [8][4][16] = '{
    '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
      '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
      '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
      '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
    '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
      '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
      '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
      '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
    '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
      '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
      '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
    '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
      '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
      '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
      '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
    '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
      '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
      '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
      '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
    '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
      '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
      '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
      '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
    '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
      '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
      '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
      '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
    '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
      '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
      '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
      '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
  };

  localparam int P_POS [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  typedef struct {
    logic [31:0] data;
    int          acc;   // cycle count at the negedge preceding acceptance
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [47:0] in_data;
  logic        out_ready;
  logic [NDUT-1:0] in_ready;
  logic [NDUT-1:0] out_valid;
  logic [NDUT-1:0] busy;
  logic [31:0] out_data [NDUT];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic chk_en   = 1'b0;
  int   in_cnt  [NDUT];
  int   out_cnt [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    longint unsigned v;
    longint unsigned r;
    int c, row, col;
    v = 64'(x);
    r = 0;
    for (int i = 0; i < 8; i++) begin
      c   = int'((v >> (42 - 6*i)) & 64'd63);
      row = (c / 32) * 2 + (c % 2);
      col = (c / 2) % 16;
      r   = r * 16 + longint'(S_TAB[i][row][col]);
    end
    return 32'(r);
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] x);
    longint unsigned v;
    longint unsigned r;
    v = 64'(x);
    r = 0;
    for (int k = 0; k < 32; k++) begin
      r = r * 2 + ((v >> (32 - P_POS[k])) & 64'd1);
    end
    return 32'(r);
  endfunction

  function automatic logic [31:0] ref_out(input logic [47:0] x, input int ap);
    return (ap != 0) ? ref_p(ref_sbox(x)) : ref_sbox(x);
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    des_sbox_pipe #(
      .PIPE_STAGES (CFG_PS[g]),
      .APPLY_P     (CFG_AP[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_data   (in_data),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    ent_t q[$];

    initial begin
      in_cnt[g]  = 0;
      out_cnt[g] = 0;
    end

    always @(negedge clk) begin
      logic exp_valid;
      ent_t e;
      if (chk_en) begin
        exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= CFG_PS[g]);
        check($sformatf("out_valid[%0d]", g), 48'(out_valid[g]), 48'(exp_valid));
        if (exp_valid)
          check($sformatf("out_data[%0d]", g), 48'(out_data[g]), 48'(q[0].data));
        check($sformatf("in_ready[%0d]", g), 48'(in_ready[g]),
              48'((q.size() < CFG_PS[g]) || out_ready));
        check($sformatf("busy[%0d]", g), 48'(busy[g]), 48'(q.size() != 0));
      end
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid[g] && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          out_cnt[g]++;
        end
        if (in_valid && in_ready[g]) begin
          e.data = ref_out(in_data, CFG_AP[g]);
          e.acc  = cyc;
          q.push_back(e);
          in_cnt[g]++;
        end
      end
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          b_in  [NDUT];
    int          b_out [NDUT];
    int          mn;
    int          budget;
    logic [47:0] bp [4];
    logic [47:0] w;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), 48'(out_valid[k]), 48'(0));
      check($sformatf("rst_busy[%0d]", k),      48'(busy[k]),      48'(0));
      check($sformatf("rst_in_ready[%0d]", k),  48'(in_ready[k]),  48'(1));
      check($sformatf("rst_out_data[%0d]", k),  48'(out_data[k]),  48'(0));
    end
    chk_en = 1'b1;

    // Zero vector, then all-ones vector: exact latency and known results.
    for (int v = 0; v < 2; v++) begin
      w = (v == 0) ? 48'h000000000000 : 48'hFFFFFFFFFFFF;
      @(posedge clk); #1 in_valid = 1'b1; in_data = w; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("vec_lat1_two_stage", 48'(out_valid[0]), 48'(0));
      check("vec_lat1_one_stage_valid", 48'(out_valid[2]), 48'(1));
      check("vec_lat1_one_stage_data", 48'(out_data[2]),
            48'((v == 0) ? 32'hEFA72C4D : 32'hD9CE3DCB));
      @(negedge clk);
      check("vec_lat2_valid", 48'(out_valid[0]), 48'(1));
      check("vec_lat2_raw", 48'(out_data[0]),
            48'((v == 0) ? 32'hEFA72C4D : 32'hD9CE3DCB));
      check("vec_lat2_perm", 48'(out_data[1]),
            48'(ref_p((v == 0) ? 32'hEFA72C4D : 32'hD9CE3DCB)));
    end

    // Streaming: 1000 back-to-back words with the sink always ready.
    repeat (3) @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin b_in[k] = in_cnt[k]; b_out[k] = out_cnt[k]; end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = rand48();
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("stream_in[%0d]", k),  48'(in_cnt[k] - b_in[k]),   48'(1000));
      check($sformatf("stream_out[%0d]", k), 48'(out_cnt[k] - b_out[k]), 48'(1000));
    end

    // Backpressure: offer 4 words with the sink stalled.
    for (int k = 0; k < NDUT; k++) begin b_in[k] = in_cnt[k]; b_out[k] = out_cnt[k]; end
    for (int i = 0; i < 4; i++) bp[i] = rand48();
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = bp[i];
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("bp_in_ready[%0d]", k), 48'(in_ready[k]), 48'(0));
        check($sformatf("bp_hold_data[%0d]", k), 48'(out_data[k]), 48'(ref_out(bp[0], CFG_AP[k])));
        check($sformatf("bp_accepted[%0d]", k), 48'(in_cnt[k] - b_in[k]), 48'(CFG_PS[k]));
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("bp_drained[%0d]", k), 48'(out_cnt[k] - b_out[k]), 48'(CFG_PS[k]));

    // Random valid/ready toggling until every instance has taken 5000 words.
    for (int k = 0; k < NDUT; k++) begin b_in[k] = in_cnt[k]; b_out[k] = out_cnt[k]; end
    budget = 0;
    mn = 0;
    while (mn < 5000 && budget < 40000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rand48();
      budget++;
      mn = in_cnt[0] - b_in[0];
      for (int k = 1; k < NDUT; k++)
        if (in_cnt[k] - b_in[k] < mn) mn = in_cnt[k] - b_in[k];
    end
    check("rand_budget", 48'(mn >= 5000), 48'(1));
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && busy != '0; c++) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rand_idle[%0d]", k), 48'(busy[k]), 48'(0));
      check($sformatf("rand_no_loss[%0d]", k),
            48'(out_cnt[k] - b_out[k]), 48'(in_cnt[k] - b_in[k]));
    end

    // Reset with two words in flight.
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = rand48();
    @(posedge clk); #1 in_data = rand48();
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_busy_before_rst", 48'(busy[0]), 48'(1));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("mid_out_valid[%0d]", k), 48'(out_valid[k]), 48'(0));
      check($sformatf("mid_busy[%0d]", k),      48'(busy[k]),      48'(0));
      check($sformatf("mid_in_ready[%0d]", k),  48'(in_ready[k]),  48'(1));
      check($sformatf("mid_out_data[%0d]", k),  48'(out_data[k]),  48'(0));
    end
    w = rand48();
    @(posedge clk); #1 in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("mid_next_one_stage", 48'(out_data[2]), 48'(ref_out(w, 0)));
    @(negedge clk);
    check("mid_next_raw", 48'(out_data[0]), 48'(ref_out(w, 0)));
    check("mid_next_perm", 48'(out_data[1]), 48'(ref_out(w, 1)));

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
